// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered NCH-channel selector with valid/ready handshaking.
// A loadable select register picks the source channel. When the macro
// MUX_SEL_RR_EN is defined, mode = 1 switches to a round-robin scan over the
// valid channels. Without the macro, mode is ignored and selection is fixed.
module mux_sel_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_bus,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [SELW-1:0]        sel,
    input  logic                   sel_load,
    input  logic                   mode,
    output logic [WIDTH-1:0]       out,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sel_err
);

    // One extra bit so that ptr + offset never overflows before the wrap test.
    typedef logic [SELW:0] wide_idx_t;

    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic             space;
    logic             have_cand;
    logic             capture;
    logic [SELW-1:0]  cand;

`ifdef MUX_SEL_RR_EN
    logic [SELW-1:0]  ptr_q, ptr_d;

    // Next channel index after idx, wrapping NCH-1 back to 0.
    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx);
        wide_idx_t nxt;
        nxt = {1'b0, idx} + wide_idx_t'(1);
        if (nxt >= wide_idx_t'(NCH)) begin
            nxt = '0;
        end
        return nxt[SELW-1:0];
    endfunction
`else
    // mode has no effect when round-robin support is not built in.
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Choose the candidate channel: the select register, or the first valid
    // channel at or after ptr when the round-robin scan is active.
    always_comb begin
        cand      = sel_q;
        have_cand = 1'b1;
`ifdef MUX_SEL_RR_EN
        if (mode) begin
            cand      = ptr_q;
            have_cand = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                wide_idx_t scan;
                scan = {1'b0, ptr_q} + wide_idx_t'(i);
                if (scan >= wide_idx_t'(NCH)) begin
                    scan = scan - wide_idx_t'(NCH);
                end
                if (!have_cand && in_valid[scan[SELW-1:0]]) begin
                    have_cand = 1'b1;
                    cand      = scan[SELW-1:0];
                end
            end
        end
`endif
    end

    // Handshake, capture decision and next-state values.
    always_comb begin
        space    = !out_valid_q || out_ready;
        in_ready = '0;
        if (!rst && space && have_cand) begin
            in_ready[cand] = 1'b1;
        end
        capture = in_valid[cand] && in_ready[cand];

        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            out_d       = in_bus[cand*WIDTH +: WIDTH];
            out_ch_d    = cand;
            out_valid_d = 1'b1;
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end

        // Out-of-range select values are rejected and flagged for one cycle.
        sel_err_d = sel_load && (int'(sel) >= NCH);
        sel_d     = sel_q;
        if (sel_load && !sel_err_d) begin
            sel_d = sel;
        end

`ifdef MUX_SEL_RR_EN
        ptr_d = ptr_q;
        if (capture && mode) begin
            ptr_d = wrap_inc(cand);
        end
`endif
    end

    // State registers; reset clears everything, including any pending capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
`ifdef MUX_SEL_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
`ifdef MUX_SEL_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised, registered N-channel selector with valid/ready handshaking. It is the next-generation replacement for the processor's fixed 8-to-1 byte multiplexer. It selects one of NCH input channels by a loadable select register, or optionally by round-robin scan over valid channels, and registers the chosen word together with its channel index. It sits between register-file/ALU sources and any consumer that can apply backpressure.

## Interface
- WIDTH, 8, data width per channel
- NCH, 8, channel count (2..16)
- SELW, 3, select/index width; must satisfy 2^SELW >= NCH
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_bus  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel data valid
- in_ready  out  NCH  per-channel accept; combinational
- sel  in  SELW  new select value
- sel_load  in  1  load sel into select register
- mode  in  1  0 = fixed select, 1 = round-robin (only with MUX_SEL_RR_EN)
- out  out  WIDTH  registered selected data
- out_ch  out  SELW  channel index of out
- out_valid  out  1  out holds an unconsumed word
- out_ready  in  1  consumer accept
- sel_err  out  1  one-cycle pulse: sel_load with sel >= NCH

## Operation
- Internal state: sel_q (SELW), ptr (SELW), output register {out, out_ch, out_valid}.
- space = !out_valid || out_ready.
- Fixed mode: cand = sel_q. in_ready[k] = space && (k == cand); all others 0. Capture when in_valid[cand] && in_ready[cand].
- Round-robin mode: cand = first k with in_valid[k], searching ptr, ptr+1, ..., wrapping at NCH-1 -> 0. If no channel is valid, no capture occurs and in_ready is all 0. On capture, ptr <= cand+1, wrapping NCH-1 -> 0.
- Capture: out <= in_bus[cand], out_ch <= cand, out_valid <= 1.
- No capture and out_ready && out_valid: out_valid <= 0. out and out_ch hold their values.
- sel_load with sel < NCH: sel_q <= sel.
- sel_load with sel >= NCH: sel_q unchanged; sel_err = 1 in the next cycle.
- sel_load is honoured in both modes. sel_q does not affect round-robin mode.
- mode is sampled combinationally each cycle. Switching mode does not change sel_q or ptr.
- While rst is high, in_ready is all 0.

## Timing
- Reset values: out = 0, out_ch = 0, out_valid = 0, sel_err = 0, sel_q = 0, ptr = 0.
- Latency: a word accepted in cycle N appears at out with out_valid = 1 after edge N+1.
- Throughput: 1 word/cycle when out_ready is held high. Simultaneous consume and capture replaces the register and keeps out_valid = 1.
- Backpressure: while out_valid && !out_ready, in_ready is all 0 and out/out_ch hold stable.
- sel_load and a capture in the same cycle: the capture uses the old sel_q. The new select applies from the next cycle.
- Round-robin ptr wrap: with ptr = NCH-1 and only channel 0 valid, channel 0 is selected and ptr <= 1.
- Reset asserted mid-transfer: the pending word is dropped, all state returns to reset values at that edge, and there is no capture in that cycle.

## Configuration
- MUX_SEL_RR_EN defined: round-robin logic and ptr are compiled in; mode selects behaviour as above.
- MUX_SEL_RR_EN undefined: mode is ignored, ptr is absent, and the block always operates in fixed mode.

## Test plan
- Reset, then fixed mode. sel_load = 1, sel = 5; then in_valid = 8'h20, channel 5 = 8'hA5, out_ready = 1. Expected: in_ready = 8'h20; the next cycle gives out = 8'hA5, out_ch = 5, out_valid = 1.
- out_ready = 0 with out_valid = 1 and all in_valid = 1. Expected: in_ready = 0 and out held for 4 cycles. Then out_ready = 1: one pop and one new capture in the same cycle.
- sel_load with sel = 3'd7, NCH = 6. Expected: sel_err pulses for 1 cycle, and sel_q keeps its previous value (checked via capture from the old channel).
- Round-robin (macro on): in_valid = 8'b1000_0101, out_ready = 1 continuously. Expected out_ch sequence: 0, 2, 7, 0, 2.
- Round-robin wrap: ptr = 7 (after a capture on channel 6), only channel 0 valid. Expected: out_ch = 0 and ptr = 1.
- rst asserted while out_valid = 1 and a capture is pending. Expected: out_valid = 0, out = 0, and no capture; the first capture after rst is released lands one cycle later.
